// File: rtl/sub_seq_slice_pkg.sv
// ============================================================================
// Module : sub_seq_slice_pkg
// Brief  : Shared types and constants for the sliced sequential subtractor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sub_seq_slice_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int c_def_width = 32;
    localparam int c_def_slice = 8;

    // A return value of 0 marks an illegal WIDTH/SLICE pairing.
    function automatic int calc_nslice(input int width, input int slice);
        if (slice > 0 && width >= slice && (width % slice) == 0)
            return width / slice;
        else
            return 0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sub_seq_slice_sub_8_bit.sv
// ============================================================================
// Module : sub_8_bit
// Brief  : Combinational SLICE-bit borrow-lookahead subtractor slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sub_8_bit #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             bin,
    output logic [SLICE-1:0] d,
    output logic             bout,
    output logic             g_out,
    output logic             p_out
);

    logic [SLICE-1:0] w_gen;
    logic [SLICE-1:0] w_prop;
    logic [SLICE:0]   w_borrow;
    logic             w_grp_g;
    logic             w_grp_p;

    // Bit i generates a borrow when a=0,b=1 and passes one through when a==b.
    assign w_gen  = ~a & b;
    assign w_prop = ~(a ^ b);

    // Each borrow is formed from the prefix group terms and bin directly,
    // so no bit waits on the borrow of the bit below it.
    always_comb begin
        logic v_g;
        logic v_p;
        v_g         = 1'b0;
        v_p         = 1'b1;
        w_borrow    = '0;
        w_borrow[0] = bin;
        for (int i = 0; i < SLICE; i++) begin
            v_g           = w_gen[i] | (w_prop[i] & v_g);
            v_p           = w_prop[i] & v_p;
            w_borrow[i+1] = v_g | (v_p & bin);
        end
        w_grp_g = v_g;
        w_grp_p = v_p;
    end

    assign d     = a ^ b ^ w_borrow[SLICE-1:0];
    assign g_out = w_grp_g;
    assign p_out = w_grp_p;
    assign bout  = w_grp_g | (w_grp_p & bin);

endmodule

`default_nettype wire

// File: rtl/sub_seq_slice.sv
// ============================================================================
// Module : sub_seq_slice
// Brief  : Multi-cycle WIDTH-bit subtractor d = a - b - b_in, one SLICE per
//          clock LSB first. Define SUB_SEQ_OVERLAP_EN to accept a new op in
//          the result-handshake cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sub_seq_slice
    import sub_seq_slice_pkg::*;
#(
    parameter int WIDTH = c_def_width,
    parameter int SLICE = c_def_slice
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             b_out,
    output logic             ovf,
    output logic             zero
);

    localparam int NSLICE = calc_nslice(WIDTH, SLICE);
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [IDXW-1:0]  c_last_idx   = IDXW'(NSLICE - 1);
    localparam logic [WIDTH-1:0] c_slice_mask = WIDTH'({SLICE{1'b1}});

    if (NSLICE < 1) begin : g_cfg_bad
        $error("sub_seq_slice: WIDTH must be a non-zero multiple of SLICE");
    end

    state_t            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_borrow;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_d;
    logic              r_b_out;
    logic              r_ovf;
    logic              r_zero;
    logic              r_out_valid;
    logic              r_in_ready;

    logic              w_accept;
    logic              w_handshake;
    logic [31:0]       w_base;
    logic [SLICE-1:0]  w_a_sl;
    logic [SLICE-1:0]  w_b_sl;
    logic [SLICE-1:0]  w_d_sl;
    logic              w_bout;
    logic              w_g;
    logic              w_p;
    logic [WIDTH-1:0]  w_d_next;
    logic              w_ovf_next;

`ifdef SUB_SEQ_OVERLAP_EN
    assign in_ready = r_in_ready | ((r_state == DONE) & out_ready);
`else
    assign in_ready = r_in_ready;
`endif

    assign w_accept    = in_valid & in_ready;
    assign w_handshake = r_out_valid & out_ready;

    assign w_base = 32'(r_idx) * 32'(SLICE);
    assign w_a_sl = r_a[w_base +: SLICE];
    assign w_b_sl = r_b[w_base +: SLICE];

    sub_8_bit #(
        .SLICE (SLICE)
    ) u_slice (
        .a     (w_a_sl),
        .b     (w_b_sl),
        .bin   (r_borrow),
        .d     (w_d_sl),
        .bout  (w_bout),
        .g_out (w_g),
        .p_out (w_p)
    );

    // Full result with the current slice merged in, so the flags registered
    // on the last RUN cycle see the MSB slice being written.
    assign w_d_next   = (r_d & ~(c_slice_mask << w_base)) | (WIDTH'(w_d_sl) << w_base);
    assign w_ovf_next = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_d_next[WIDTH-1] != r_a[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_borrow    <= 1'b0;
            r_idx       <= '0;
            r_d         <= '0;
            r_b_out     <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_borrow   <= b_in;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_d      <= w_d_next;
                    r_borrow <= w_bout;
                    if (r_idx == c_last_idx) begin
                        r_b_out     <= w_g | (w_p & r_borrow);
                        r_ovf       <= w_ovf_next;
                        r_zero      <= (w_d_next == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (w_handshake) begin
                        r_out_valid <= 1'b0;
`ifdef SUB_SEQ_OVERLAP_EN
                        if (w_accept) begin
                            r_a      <= a;
                            r_b      <= b;
                            r_borrow <= b_in;
                            r_idx    <= '0;
                            r_state  <= RUN;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_state    <= IDLE;
                        end
`else
                        r_in_ready <= 1'b1;
                        r_state    <= IDLE;
`endif
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign d         = r_d;
    assign b_out     = r_b_out;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_sub_seq_slice.sv
// ============================================================================
// Module : tb_sub_seq_slice
// Brief  : Self-checking bench for sub_seq_slice (WIDTH=32, SLICE=8).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sub_seq_slice;

    localparam int c_width  = 32;
    localparam int c_slice  = 8;
    localparam int c_nslice = c_width / c_slice;
`ifdef SUB_SEQ_OVERLAP_EN
    localparam int c_period = c_nslice + 1;
`else
    localparam int c_period = c_nslice + 2;
`endif

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [c_width-1:0] a;
    logic [c_width-1:0] b;
    logic              b_in;
    logic              out_valid;
    logic              out_ready;
    logic [c_width-1:0] d;
    logic              b_out;
    logic              ovf;
    logic              zero;

    int n_tests = 0;
    int n_fail  = 0;

    sub_seq_slice #(
        .WIDTH (c_width),
        .SLICE (c_slice)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .b_out     (b_out),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] d;
        logic        bout;
        logic        ovf;
        logic        zero;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: 33-bit arithmetic, borrow is the wrap into bit 32.
    task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mbin,
                         output logic [31:0] ed, output logic eb, output logic eo, output logic ez);
        logic [32:0] full;
        full = {1'b0, ma} - {1'b0, mb} - {32'd0, mbin};
        ed   = full[31:0];
        eb   = full[32];
        eo   = (ma[31] != mb[31]) && (ed[31] != ma[31]);
        ez   = (ed == 32'd0);
    endtask

    task automatic run_op(input logic [31:0] va, input logic [31:0] vb, input logic vbin,
                          input logic [31:0] ed, input logic eb, input logic eo, input logic ez,
                          input int hold, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
        a = va; b = vb; b_in = vbin; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = $urandom; b = $urandom; b_in = 1'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        chk({tag, " latency"}, 64'(n), 64'(c_nslice));
        for (int i = 0; i < hold; i++) tick();
        chk({tag, " d"},     64'(d),     64'(ed));
        chk({tag, " b_out"}, 64'(b_out), 64'(eb));
        chk({tag, " ovf"},   64'(ovf),   64'(eo));
        chk({tag, " zero"},  64'(zero),  64'(ez));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[7];
        logic [31:0] ed, d0, ra, rb;
        logic        eb, eo, ez, rbin;
        logic [3:0]  f0;
        int          n, last, gaps;

        vecs[0] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{32'h12345678, 32'h12345677, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'h0000000A, 32'h00000004, 1'b0, 32'h00000006, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; b_in = 1'b0;
        repeat (3) tick();
        chk("reset in_ready",  64'(in_ready),  64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset d",         64'(d),         64'd0);
        chk("reset flags",     64'({b_out, ovf, zero}), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bout,
                   vecs[i].ovf, vecs[i].zero, 0, $sformatf("vec%0d", i));

        // Stall in DONE, and poke inputs while RUN.
        a = 32'h00001000; b = 32'h00002000; b_in = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        a = 32'hDEADBEEF; b = 32'h0; in_valid = 1'b1;
        chk("run in_ready", 64'(in_ready), 64'd0);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        model(32'h00001000, 32'h00002000, 1'b1, ed, eb, eo, ez);
        chk("stall d", 64'(d), 64'(ed));
        chk("stall flags", 64'({b_out, ovf, zero}), 64'({eb, eo, ez}));
        d0 = d; f0 = {b_out, ovf, zero, out_valid};
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            tick();
            chk("stall hold d", 64'(d), 64'(d0));
            chk("stall hold flags", 64'({b_out, ovf, zero, out_valid}), 64'(f0));
            chk("stall in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();

        // Reset while at slice index 2.
        a = 32'h55555555; b = 32'h11111111; b_in = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", 64'(out_valid), 64'd0);
        chk("abort d",         64'(d),         64'd0);
        chk("abort in_ready",  64'(in_ready),  64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        run_op(32'h0000000A, 32'h00000004, 1'b0, 32'h00000006, 1'b0, 1'b0, 1'b0, 0, "post-abort");

        // Back-to-back throughput with in_valid and out_ready held high.
        a = 32'h00000009; b = 32'h00000002; b_in = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        n = 0; last = -1; gaps = 0;
        while (gaps < 3 && n < 60) begin
            tick(); n++;
            if (out_valid) begin
                chk("b2b d", 64'(d), 64'h7);
                if (last >= 0) begin
                    chk("b2b period", 64'(n - last), 64'(c_period));
                    gaps++;
                end
                last = n;
            end
        end
        chk("b2b completed", 64'(gaps), 64'd3);
        in_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        while (out_valid && n < 20) begin tick(); n++; end
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end

        // Randomized operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra   = $urandom;
            rb   = (i % 5 == 0) ? ra : $urandom;
            rbin = 1'($urandom);
            model(ra, rb, rbin, ed, eb, eo, ez);
            run_op(ra, rb, rbin, ed, eb, eo, ez, $urandom_range(0, 3), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
